// File: rtl/kyber_pkg.sv
// Shared Kyber constants and datapath types for the polynomial and serialisation blocks.
package kyber_pkg;

    localparam int KYBER_N = 256;
    localparam int KYBER_Q = 3329;

    typedef logic signed [15:0] coeff_t;
    typedef logic        [7:0]  byte_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } enc_state_t;

endpackage

// File: rtl/coeff_canon.sv
// Combinational mod-q canonicaliser: maps any signed 16-bit coefficient into [0, q).
module coeff_canon
    import kyber_pkg::*;
(
    input  coeff_t      coeff_i,
    output logic [11:0] canon_o
);

    localparam int STAGES = 5;

    logic [16:0] stage_v [0:STAGES];

    // A 10q offset makes every input non-negative without changing its residue;
    // the result is below 32q, so a binary chain subtracting 16q..q finishes it.
    assign stage_v[0] = 17'(int'(coeff_i) + 10 * KYBER_Q);

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_sub
        localparam logic [16:0] SUB = 17'(KYBER_Q << (STAGES - 1 - gi));
        assign stage_v[gi+1] = (stage_v[gi] >= SUB) ? (stage_v[gi] - SUB) : stage_v[gi];
    end

    assign canon_o = 12'(stage_v[STAGES]);

endmodule

// File: rtl/byte_encode.sv
// Kyber ByteEncode_d packer: one coefficient per cycle, D bits LSB-first into MSB-first bytes.
// Define BYTE_ENCODE_CANON_EN to reduce each coefficient mod q before packing.
module byte_encode
    import kyber_pkg::*;
#(
    parameter int D        = 8,
    parameter int BYTE_LEN = 32,
    parameter int N        = KYBER_N
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   start,
    input  coeff_t F [0:N-1],
    output byte_t  B [0:BYTE_LEN*D-1],
    output logic   busy,
    output logic   done
);

    localparam int NBYTES = BYTE_LEN * D;
    localparam int NBITS  = 8 * NBYTES;
    localparam int PW     = $clog2(NBITS);
    localparam int IW     = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    enc_state_t    state_q, state_d;
    logic [IW-1:0] idx_q;
    logic [PW-1:0] pos_q;
    logic          done_q, done_d;
    logic          accept;
    logic [D-1:0]  v;
    coeff_t        f_q [0:N-1];
    byte_t         b_q [0:NBYTES-1];
    logic [PW-1:0] bit_addr [0:D-1];

    assign accept = (state_q == ST_IDLE) && start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ST_BUSY;
            ST_BUSY: if (idx_q == LAST_IDX) state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy   = (state_q == ST_BUSY);
        done_d = (state_q == ST_BUSY) && (idx_q == LAST_IDX);
    end

`ifdef BYTE_ENCODE_CANON_EN
    logic [11:0] canon;

    coeff_canon u_canon (
        .coeff_i (f_q[idx_q]),
        .canon_o (canon)
    );

    assign v = D'(canon);
`else
    assign v = D'(f_q[idx_q]);
`endif

    // Stream position of each of this cycle's D bits.
    for (genvar gi = 0; gi < D; gi++) begin : g_addr
        assign bit_addr[gi] = pos_q + PW'(gi);
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            f_q <= F;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
            pos_q <= '0;
            for (int k = 0; k < NBYTES; k++) b_q[k] <= '0;
        end else if (accept) begin
            idx_q <= '0;
            pos_q <= '0;
            for (int k = 0; k < NBYTES; k++) b_q[k] <= '0;
        end else if (state_q == ST_BUSY) begin
            idx_q <= idx_q + 1'b1;
            pos_q <= pos_q + PW'(D);
            for (int j = 0; j < D; j++) begin
                b_q[bit_addr[j][PW-1:3]][3'd7 - bit_addr[j][2:0]] <= v[j];
            end
        end
    end

    assign B    = b_q;
    assign done = done_q;

endmodule

// File: tb/tb_byte_encode.sv
// Scoreboard bench for byte_encode at D = 8, 1 and 12 sharing one clock and reset.
`timescale 1ns/1ps
module tb_byte_encode;
    import kyber_pkg::*;

    typedef byte_t exp_t [0:383];
    typedef struct {
        int   sel;
        exp_t b;
    } sb_t;

    logic   clk = 1'b0;
    logic   rst_n;
    logic   start8, start1, start12;
    coeff_t f8 [0:255];
    coeff_t f1 [0:255];
    coeff_t f12 [0:255];
    byte_t  b8 [0:255];
    byte_t  b1 [0:31];
    byte_t  b12 [0:383];
    logic   busy8, busy1, busy12;
    logic   done8, done1, done12;

    int     n_cmp = 0;
    int     n_err = 0;
    sb_t    sb_q[$];
    coeff_t fa [0:255];

    always #5 clk = ~clk;

    byte_encode #(.D(8)) u_enc8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .F(f8), .B(b8), .busy(busy8), .done(done8)
    );
    byte_encode #(.D(1)) u_enc1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .F(f1), .B(b1), .busy(busy1), .done(done1)
    );
    byte_encode #(.D(12)) u_enc12 (
        .clk(clk), .rst_n(rst_n), .start(start12), .F(f12), .B(b12), .busy(busy12), .done(done12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_byte(input int sel, input int k);
        case (sel)
            8:       return {24'd0, b8[k]};
            1:       return {24'd0, b1[k]};
            default: return {24'd0, b12[k]};
        endcase
    endfunction

    function automatic logic done_of(input int sel);
        case (sel)
            8:       return done8;
            1:       return done1;
            default: return done12;
        endcase
    endfunction

    function automatic logic busy_of(input int sel);
        case (sel)
            8:       return busy8;
            1:       return busy1;
            default: return busy12;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: build the LSB-first bit stream, then pack it MSB-first into bytes.
    task automatic go(input int sel);
        sb_t  e;
        logic strm [0:3071];
        int   v;
        e.sel = sel;
        for (int i = 0; i < 256; i++) begin
            v = int'(fa[i]);
`ifdef BYTE_ENCODE_CANON_EN
            while (v < 0) v += 3329;
            while (v >= 3329) v -= 3329;
`endif
            for (int j = 0; j < sel; j++) strm[i*sel + j] = v[j];
        end
        for (int k = 0; k < 384; k++) begin
            e.b[k] = 8'h00;
            if (k < 32 * sel) begin
                for (int m = 0; m < 8; m++) e.b[k][7-m] = strm[8*k + m];
            end
        end
        sb_q.push_back(e);
        case (sel)
            8:       begin f8 = fa;  start8 = 1'b1;  end
            1:       begin f1 = fa;  start1 = 1'b1;  end
            default: begin f12 = fa; start12 = 1'b1; end
        endcase
        step();
        start8 = 1'b0;
        start1 = 1'b0;
        start12 = 1'b0;
    endtask

    task automatic compare(input int sel, input string tag);
        sb_t e;
        int  errs0;
        errs0 = n_err;
        if (sb_q.size() == 0) begin
            check({tag, " scoreboard_empty"}, 32'd1, 32'd0);
            return;
        end
        e = sb_q.pop_front();
        check({tag, " sb_sel"}, e.sel, sel);
        for (int k = 0; k < 32 * sel; k++) begin
            check($sformatf("%s B[%0d]", tag, k), obs_byte(sel, k), {24'd0, e.b[k]});
        end
        $display("run %s: D=%0d, %0d bytes compared, %0d mismatched", tag, sel, 32 * sel, n_err - errs0);
    endtask

    task automatic wait_done(input int sel, input int cnt0, input string tag);
        int cnt;
        bit seen;
        cnt = cnt0;
        seen = 1'b0;
        while (!seen && cnt < 400) begin
            step();
            cnt++;
            seen = (done_of(sel) === 1'b1);
        end
        check({tag, " latency"}, cnt, 256);
        check({tag, " busy_at_done"}, {31'd0, busy_of(sel)}, 32'd0);
        compare(sel, tag);
    endtask

    initial begin
        int nz;
        rst_n = 1'b1;
        start8 = 1'b0;
        start1 = 1'b0;
        start12 = 1'b0;
        for (int i = 0; i < 256; i++) begin
            fa[i] = '0;
            f8[i] = '0;
            f1[i] = '0;
            f12[i] = '0;
        end
        #2 rst_n = 1'b0;
        #10;
        check("rst busy8", {31'd0, busy8}, 32'd0);
        check("rst done8", {31'd0, done8}, 32'd0);
        check("rst busy12", {31'd0, busy12}, 32'd0);
        check("rst b8[0]", obs_byte(8, 0), 32'd0);
        check("rst b12[383]", obs_byte(12, 383), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        step();

        // D=8 ramp gives bit-reversed indices
        for (int i = 0; i < 256; i++) fa[i] = coeff_t'(i);
        go(8);
        wait_done(8, 0, "d8_ramp");
        check("d8 B[0]", obs_byte(8, 0), 32'd0);
        check("d8 B[1]", obs_byte(8, 1), 32'd128);
        check("d8 B[2]", obs_byte(8, 2), 32'd64);
        check("d8 B[3]", obs_byte(8, 3), 32'd192);
        check("d8 B[254]", obs_byte(8, 254), 32'd127);
        check("d8 B[255]", obs_byte(8, 255), 32'd255);
        step();
        check("d8 done_one_cycle", {31'd0, done8}, 32'd0);
        check("d8 B_hold", obs_byte(8, 1), 32'd128);

        // D=1 alternating bits, then an immediate back-to-back run
        for (int i = 0; i < 256; i++) fa[i] = coeff_t'(i & 1);
        go(1);
        wait_done(1, 0, "d1_alt");
        check("d1 B[0]", obs_byte(1, 0), 32'h55);
        check("d1 B[31]", obs_byte(1, 31), 32'h55);
        for (int i = 0; i < 256; i++) fa[i] = coeff_t'($urandom);
        go(1);
        check("d1 b2b done_low", {31'd0, done1}, 32'd0);
        check("d1 b2b busy", {31'd0, busy1}, 32'd1);
        wait_done(1, 0, "d1_b2b");

        // D=12 single full-scale coefficient
        for (int i = 0; i < 256; i++) fa[i] = '0;
        fa[0] = 16'sh0FFF;
        go(12);
        wait_done(12, 0, "d12_fff");
        check("d12 fff B[0]", obs_byte(12, 0), 32'hFF);
        check("d12 fff B[1]", obs_byte(12, 1), 32'hF0);
        check("d12 fff B[2]", obs_byte(12, 2), 32'h00);

        // D=12 with F[0] = -1
        fa[0] = -16'sd1;
        go(12);
        wait_done(12, 0, "d12_neg1");
`ifdef BYTE_ENCODE_CANON_EN
        check("d12 neg1 B[0]", obs_byte(12, 0), 32'h00);
        check("d12 neg1 B[1]", obs_byte(12, 1), 32'hB0);
`else
        check("d12 neg1 B[0]", obs_byte(12, 0), 32'hFF);
        check("d12 neg1 B[1]", obs_byte(12, 1), 32'hF0);
`endif

        // D=12 random with range extremes and q boundaries
        for (int i = 0; i < 256; i++) fa[i] = coeff_t'($urandom);
        fa[0] = -16'sd32768;
        fa[1] = 16'sd32767;
        fa[2] = 16'sd3329;
        fa[3] = -16'sd3329;
        fa[4] = 16'sd3328;
        go(12);
        wait_done(12, 0, "d12_rand");

        // start during busy is ignored
        for (int i = 0; i < 256; i++) fa[i] = coeff_t'($urandom);
        go(8);
        repeat (99) step();
        check("d8 ignore busy", {31'd0, busy8}, 32'd1);
        for (int i = 0; i < 256; i++) f8[i] = coeff_t'($urandom);
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        wait_done(8, 100, "d8_ignore");

        // asynchronous abort mid-run, then a clean run
        for (int i = 0; i < 256; i++) fa[i] = coeff_t'($urandom);
        go(12);
        repeat (49) step();
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("abort busy12", {31'd0, busy12}, 32'd0);
        check("abort done12", {31'd0, done12}, 32'd0);
        nz = 0;
        for (int k = 0; k < 384; k++) if (obs_byte(12, k) !== 32'd0) nz++;
        check("abort b12 nonzero_bytes", nz, 32'd0);
        if (sb_q.size() != 0) void'(sb_q.pop_back());
        $display("run d12_abort: reset applied after 50 cycles");
        @(negedge clk) rst_n = 1'b1;
        step();
        for (int i = 0; i < 256; i++) fa[i] = coeff_t'($urandom);
        go(12);
        wait_done(12, 0, "d12_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/byte_encode.md
# byte_encode

Clocked Kyber ByteEncode_d packer. It serialises 256 coefficients, taking D bits from each, into a 32·D-byte array. The array is used for ciphertext and public-key serialisation in the Kyber-768 datapath. It sits between the polynomial arithmetic units, which produce F, and the byte-stream output logic, which consumes B.

## Interface
- D, 8: bits per coefficient; legal range 1..12.
- BYTE_LEN, 32: bytes per coefficient bit; the output holds BYTE_LEN·D bytes.
- N, 256: coefficient count. Fixed; not to be overridden.

- clk  input  1  rising-edge clock.
- rst_n  input  1  reset. One clock; reset is asynchronous and active-low.
- start  input  1  request; sampled only while idle.
- F  input  [0:N-1] × 16 signed  coefficient array; captured on accepted start.
- B  output  [0:BYTE_LEN·D-1] × 8  packed bytes; registered.
- busy  output  1  high while encoding.
- done  output  1  one-cycle pulse when B is complete.

## Operation
- Idle state: start=1 captures all of F into an internal array, clears B to zero, sets index i=0, and enters Busy.
- Busy state: one coefficient per cycle, in order i = 0..255.
  - v = low D bits of F[i]; see Configuration for the alternative.
  - v is appended LSB-first to a bit stream. For bit j of coefficient i, s[i·D+j] = v[j].
  - Bytes are formed MSB-first. Bit (7−m) of B[k] = s[8k+m].
  - For D=8 this makes B[i] the 8-bit bit-reversal of F[i][7:0].
- Bits may be written into B as they are produced. The partial contents of B are unspecified to users while busy=1.
- After coefficient 255 is processed, return to Idle and pulse done.
- start during Busy is ignored; it is neither queued nor a restart.
- Bits above D of each coefficient are discarded, with no saturation.

## Timing
- Reset values: B all 0, busy 0, done 0, state Idle, i=0.
- Reset is asynchronous. Asserting rst_n low mid-operation aborts immediately and restores the reset values.
- Accepted start at edge 0 → busy=1 after edge 0. Coefficient i is processed on edge i+1.
- After edge 256: busy=0 and done=1 for exactly one cycle.
- Latency: 256 cycles from start to done.
- B holds its final value from done until the next accepted start, which clears it.
- start is accepted in the same cycle that done is high, because the block is already Idle. That gives back-to-back encodes with 257-cycle spacing.

## Configuration
- BYTE_ENCODE_CANON_EN, when defined:
  - Each coefficient is canonicalised to [0, q), q=3329, before the low D bits are taken.
  - Negative values: add q, repeatedly if needed, for the signed 16-bit range.
  - Values ≥ q: subtract q until below q.
  - Canonicalisation completes in the same per-coefficient cycle, so latency is unchanged.
- When not defined: raw two's-complement low D bits are used, with no reduction.

## Structure
- Shared package kyber_pkg holds:
  - KYBER_N=256 and KYBER_Q=3329;
  - the coefficient typedef coeff_t (signed 16);
  - the byte typedef byte_t.
- One sub-module: coeff_canon, the mod-q canonicaliser. It is only instantiated under BYTE_ENCODE_CANON_EN.
- Control lives in the top: a two-state FSM, an 8-bit index, and a bit-position counter.

## Test plan
- D=8, F[i]=i, start → done 256 cycles later. B[i]=bitrev8(i): B[0]=0, B[1]=128, B[2]=64, B[3]=192, B[254]=127, B[255]=255.
- D=1, F[i]=i&1 → all 32 bytes = 0x55.
- D=12, F[0]=0x0FFF, rest 0 → B[0]=0xFF, B[1]=0xF0, B[2..383]=0x00.
- D=12, F[0]=−1, rest 0:
  - with BYTE_ENCODE_CANON_EN, F[0] becomes 3328 → B[0]=0x00, B[1]=0xB0, rest 0;
  - without it → B[0]=0xFF, B[1]=0xF0.
- Pulse start again at cycle 100 of a busy run → ignored. done still arrives at cycle 256 with the first run's data.
- Pull rst_n low at cycle 50 → busy=0, done=0, B all 0 immediately. A following start yields a full correct run.
